// File: rtl/alu_seq_pkg.sv
// Shared types for the sequential ALU: opcode encoding, control states and
// the default operand width.
package alu_seq_pkg;

    localparam int W_DEFAULT = 8;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_MUL = 3'b010,
        OP_XOR = 3'b011,
        OP_AND = 3'b100,
        OP_OR  = 3'b101
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/alu_seq_mul.sv
// Radix-2 shift-add multiplier: loads on start, then runs exactly W iterations
// regardless of operand values. done flags the edge of the final iteration.
module alu_seq_mul #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           done,
    output logic [2*W-1:0] product
);

    localparam int CW = $clog2(W + 1);

    logic [2*W-1:0] acc_q;
    logic [2*W-1:0] mcand_q;
    logic [W-1:0]   mplier_q;
    logic [CW-1:0]  cnt_q;
    logic           busy_q;
    logic [2*W-1:0] acc_d;

    // Accumulator value after the current iteration's conditional add.
    always_comb begin
        acc_d = acc_q;
        if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
        end else begin
            acc_d = acc_q;
        end
    end

    // product is the post-iteration value so the parent can capture it on the done edge.
    assign done    = busy_q && (cnt_q == CW'(W - 1));
    assign product = acc_d;

    // Iteration state: load on start, shift/accumulate while busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else if (start) begin
            acc_q    <= '0;
            mcand_q  <= {{W{1'b0}}, a};
            mplier_q <= b;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
        end else if (busy_q) begin
            acc_q    <= acc_d;
            mcand_q  <= {mcand_q[2*W-2:0], 1'b0};
            mplier_q <= {1'b0, mplier_q[W-1:1]};
            cnt_q    <= cnt_q + CW'(1);
            busy_q   <= !done;
        end else begin
            acc_q    <= acc_q;
            mcand_q  <= mcand_q;
            mplier_q <= mplier_q;
            cnt_q    <= cnt_q;
            busy_q   <= busy_q;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshakes: single-cycle logic/arith ops
// complete in one cycle, MUL runs on the iterative multiplier for W cycles.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic [2:0]     opcode,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] result,
    output logic           zero,
    output logic           err
);

    state_e         state_q;
    logic [2*W-1:0] result_q;
    logic           zero_q;
    logic           err_q;
    logic           in_ready_q;
    logic           out_valid_q;

    logic [2*W-1:0] a_ext_s;
    logic [2*W-1:0] b_ext_s;
    logic [2*W-1:0] alu_d;
    logic           illegal_d;
    logic           accept_s;
    logic           mul_start_s;
    logic           mul_done_s;
    logic [2*W-1:0] mul_product_s;

    assign a_ext_s     = {{W{1'b0}}, a};
    assign b_ext_s     = {{W{1'b0}}, b};
    assign accept_s    = in_valid && in_ready_q;
    assign mul_start_s = accept_s && (opcode == OP_MUL);

    // Single-cycle operation result; MUL is produced by the sub-module instead.
    always_comb begin
        alu_d     = '0;
        illegal_d = 1'b0;
        case (opcode)
            OP_ADD:  alu_d = a_ext_s + b_ext_s;
            OP_SUB:  alu_d = a_ext_s - b_ext_s;
            OP_MUL:  alu_d = '0;
            OP_XOR:  alu_d = a_ext_s ^ b_ext_s;
            OP_AND:  alu_d = a_ext_s & b_ext_s;
            OP_OR:   alu_d = a_ext_s | b_ext_s;
            default: begin
                alu_d     = '0;
                illegal_d = 1'b1;
            end
        endcase
    end

    alu_seq_mul #(.W(W)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start_s),
        .a       (a),
        .b       (b),
        .done    (mul_done_s),
        .product (mul_product_s)
    );

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            result_q    <= '0;
            zero_q      <= 1'b0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept_s && (opcode == OP_MUL)) begin
                        state_q    <= ST_BUSY;
                        in_ready_q <= 1'b0;
                    end else if (accept_s) begin
                        state_q     <= ST_DONE;
                        result_q    <= alu_d;
                        zero_q      <= (alu_d == '0);
                        err_q       <= illegal_d;
                        in_ready_q  <= 1'b0;
                        out_valid_q <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (mul_done_s) begin
                        state_q     <= ST_DONE;
                        result_q    <= mul_product_s;
                        zero_q      <= (mul_product_s == '0);
                        err_q       <= 1'b0;
                        out_valid_q <= 1'b1;
                    end else begin
                        state_q <= ST_BUSY;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_q     <= ST_IDLE;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                    end else begin
                        state_q <= ST_DONE;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign err       = err_q;

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The module SHALL have parameter W, default 8, giving the operand width in bits (legal values 2..32).
REQ-002 Port `clk`: input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-003 Port `rst`: input, 1 bit, synchronous active-high reset.
REQ-004 Port `in_valid`: input, 1 bit, operation request is present.
REQ-005 Port `in_ready`: output, 1 bit, the block can accept a request.
REQ-006 Port `a`: input, W bits, operand A, unsigned.
REQ-007 Port `b`: input, W bits, operand B, unsigned.
REQ-008 Port `opcode`: input, 3 bits, operation select.
REQ-009 Port `out_valid`: output, 1 bit, result is present.
REQ-010 Port `out_ready`: input, 1 bit, the consumer accepts the result.
REQ-011 Port `result`: output, 2W bits, operation result.
REQ-012 Port `zero`: output, 1 bit, set when result is zero.
REQ-013 Port `err`: output, 1 bit, set when the opcode was illegal.

Function
REQ-014 A request SHALL be accepted in a cycle with in_valid && in_ready; a, b and opcode SHALL be captured at that edge.
REQ-015 Opcodes SHALL be: 000 ADD, 001 SUB, 010 MUL, 011 XOR, 100 AND, 101 OR; 110 and 111 are illegal.
REQ-016 Operands SHALL be zero-extended to 2W bits; every result is taken modulo 2^(2W).
- ADD carry appears in bit W.
- SUB underflow wraps, e.g. W=8: 3-5 = 16'hFFFE.
REQ-017 The state machine SHALL have exactly three states: IDLE, BUSY, DONE.
REQ-018 in_ready SHALL be 1 only in IDLE.
REQ-019 out_valid SHALL be 1 only in DONE.
REQ-020 IDLE transitions on accept:
- ADD, SUB, XOR, AND, OR and illegal opcodes go to DONE.
- MUL goes to BUSY.
- Single-cycle ops therefore assert out_valid on the cycle after the accept.
REQ-021 MUL SHALL be a radix-2 shift-add over exactly W BUSY cycles; BUSY goes to DONE after the W-th iteration.
- out_valid asserts W+1 cycles after the accept.
- The product is exact: a*b < 2^(2W).
REQ-022 In DONE, the block SHALL return to IDLE on out_valid && out_ready; otherwise result, zero and err SHALL be held stable.
REQ-023 Only IDLE accepts requests: in_valid while BUSY or DONE SHALL be ignored and not queued.
- The source must hold its request until in_ready.
- Maximum throughput is one single-cycle op per 2 cycles.
REQ-024 An illegal opcode SHALL produce result=0 and err=1.
- err SHALL be 0 for every legal opcode.
REQ-025 zero SHALL equal (result == 0) for every completed operation, including illegal ones.
REQ-026 Operand values SHALL have no effect on timing; MUL by 0 still takes W iteration cycles.

Reset
REQ-027 While rst=1 at a clock edge, the block SHALL enter IDLE and clear:
- result = 0
- zero = 0
- err = 0
- out_valid = 0
- in_ready = 1 from the following cycle
REQ-028 Reset during BUSY or DONE SHALL abandon the operation with no result delivered.
- rst has priority over a simultaneous accept or handshake.

Structure
REQ-029 The package alu_seq_pkg SHALL hold:
- the opcode enum (3 bits)
- the state enum (IDLE, BUSY, DONE)
- the default width constant
REQ-030 The iterative multiplier SHALL be a separate sub-module, alu_seq_mul, with:
- inputs: clk, rst, start, a, b
- outputs: done, product (2W bits)
- it SHALL be parametrised by W.
REQ-031 All outputs SHALL be driven from registers; there SHALL be no combinational path from inputs to result.

Verification (W=8)
REQ-032 The bench SHALL cover at least these six directed scenarios:
- ADD 200+100, out_ready=1: out_valid 1 cycle after accept, result=16'h012C, zero=0, err=0.
- SUB 3-5: result=16'hFFFE; SUB 7-7: result=0, zero=1.
- MUL 255*255: in_ready=0 for 9 cycles; out_valid on cycle 9 after accept; result=16'hFE01; in_valid pulses during BUSY are ignored.
- XOR 8'hA5^8'hFF with out_ready=0 for 3 cycles: result=16'h005A held stable with out_valid=1 throughout; IDLE and in_ready=1 the cycle after out_ready=1.
- Opcode 3'b110: result=0, err=1, zero=1; a following AND 8'hF0&8'h3C gives result=16'h0030, err=0.
- rst=1 on the 4th BUSY cycle of a MUL: next cycle out_valid=0, result=0, in_ready=1; a new ADD 1+1 then gives result=2.
